// File: rtl/sync_track_ctrl.sv
// PSS frame-timing tracker: search for a first detection, verify the period, then track with a flywheel.
// States: IDLE | SEARCH (hunt first PSS) | VERIFY (confirm spacing) | TRACK (locked, flywheel on misses)
module sync_track_ctrl #(
  parameter int pFRAME_W = 16,
  parameter int pLOCK_N  = 3,
  parameter int pLOSS_N  = 4
) (
  input  logic                iclk,
  input  logic                ireset,
  input  logic                iena,
  input  logic                istart,
  input  logic                iabort,
  input  logic [pFRAME_W-1:0] iframe_len,
  input  logic [6:0]          iwin_half,
  input  logic                isop_sync,
  output logic                ocorr_sop,
  output logic [1:0]          ostate,
  output logic                olock,
  output logic                oframe_sop,
  output logic signed [7:0]   otime_err
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SEARCH = 2'd1,
    ST_VERIFY = 2'd2,
    ST_TRACK  = 2'd3
  } state_t;

  localparam logic [3:0] LOCK_LAST = 4'(pLOCK_N - 1);
  localparam logic [3:0] LOSS_LAST = 4'(pLOSS_N - 1);

  state_t              state;
  logic [pFRAME_W-1:0] pcnt;
  logic [pFRAME_W-1:0] frame_len;
  logic [6:0]          win_half;
  logic                armed;
  logic [3:0]          hit_cnt;
  logic [3:0]          miss_cnt;

  logic [pFRAME_W-1:0] win_ext;
  logic [pFRAME_W-1:0] pcnt_next;
  logic [pFRAME_W-1:0] early_diff;
  logic                in_win;
  logic                accept;
  logic                close;
  logic                arm_point;
  logic [7:0]          terr_calc;

  assign win_ext    = pFRAME_W'(win_half);
  assign in_win     = (pcnt >= frame_len - win_ext) || (pcnt <= win_ext);
  assign accept     = iena & isop_sync & armed & in_win;
  // A detection landing exactly on the last window sample is an accept, not a miss.
  assign close      = iena & armed & (pcnt == win_ext) & ~accept;
  assign arm_point  = (pcnt == frame_len - win_ext - 1'b1);
  assign pcnt_next  = (pcnt == frame_len - 1'b1) ? '0 : pcnt + 1'b1;
  assign early_diff = pcnt - frame_len;
  assign terr_calc  = (pcnt <= win_ext) ? pcnt[7:0] : early_diff[7:0];
  assign ostate     = state;

  always_ff @(posedge iclk or posedge ireset) begin
    if (ireset) begin
      state      <= ST_IDLE;
      pcnt       <= '0;
      frame_len  <= '0;
      win_half   <= '0;
      armed      <= 1'b0;
      hit_cnt    <= '0;
      miss_cnt   <= '0;
      ocorr_sop  <= 1'b0;
      olock      <= 1'b0;
      oframe_sop <= 1'b0;
      otime_err  <= '0;
    end else begin
      ocorr_sop  <= 1'b0;
      oframe_sop <= 1'b0;
      if (iabort) begin
        state    <= ST_IDLE;
        pcnt     <= '0;
        armed    <= 1'b0;
        hit_cnt  <= '0;
        miss_cnt <= '0;
        olock    <= 1'b0;
      end else if (istart) begin
        state     <= ST_SEARCH;
        pcnt      <= '0;
        armed     <= 1'b0;
        hit_cnt   <= '0;
        miss_cnt  <= '0;
        frame_len <= iframe_len;
        win_half  <= iwin_half;
        olock     <= 1'b0;
        ocorr_sop <= 1'b1;
      end else begin
        case (state)
          ST_SEARCH: begin
            if (iena && isop_sync) begin
              state     <= ST_VERIFY;
              pcnt      <= pFRAME_W'(1);
              armed     <= 1'b0;
              hit_cnt   <= 4'd1;
              otime_err <= '0;
            end
          end
          ST_VERIFY, ST_TRACK: begin
            if (iena) begin
              pcnt <= accept ? pFRAME_W'(1) : pcnt_next;
              if (accept || close)
                armed <= 1'b0;
              else if (arm_point)
                armed <= 1'b1;
              if (accept)
                otime_err <= terr_calc;

              if (state == ST_VERIFY) begin
                if (accept) begin
                  hit_cnt <= hit_cnt + 4'd1;
                  if (hit_cnt == LOCK_LAST) begin
                    state      <= ST_TRACK;
                    olock      <= 1'b1;
                    miss_cnt   <= '0;
                    oframe_sop <= 1'b1;
                  end
                end else if (close) begin
                  state     <= ST_SEARCH;
                  pcnt      <= '0;
                  hit_cnt   <= '0;
                  ocorr_sop <= 1'b1;
                end
              end else begin
                if (accept) begin
                  miss_cnt   <= '0;
                  oframe_sop <= 1'b1;
                end else if (close) begin
                  if (miss_cnt == LOSS_LAST) begin
                    // Lock lost: fall back to a fresh search with a re-armed correlator.
                    state     <= ST_SEARCH;
                    pcnt      <= '0;
                    hit_cnt   <= '0;
                    miss_cnt  <= '0;
                    olock     <= 1'b0;
                    ocorr_sop <= 1'b1;
                  end else begin
                    miss_cnt   <= miss_cnt + 4'd1;
                    oframe_sop <= 1'b1;
                  end
                end
              end
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_sync_track_ctrl.sv
// Bench for sync_track_ctrl: vector table, directed frame-timing sequences, and random traffic
// compared against a sample-index based tracking model.
module tb_sync_track_ctrl;

  localparam int LOCK_N = 3;
  localparam int LOSS_N = 4;

  logic              iclk = 1'b0;
  logic              ireset = 1'b1;
  logic              iena = 1'b0;
  logic              istart = 1'b0;
  logic              iabort = 1'b0;
  logic [15:0]       iframe_len = 16'd100;
  logic [6:0]        iwin_half = 7'd4;
  logic              isop_sync = 1'b0;
  logic              ocorr_sop;
  logic [1:0]        ostate;
  logic              olock;
  logic              oframe_sop;
  logic signed [7:0] otime_err;

  int total = 0;
  int bad = 0;

  sync_track_ctrl #(.pFRAME_W(16), .pLOCK_N(LOCK_N), .pLOSS_N(LOSS_N)) dut (
    .iclk(iclk), .ireset(ireset), .iena(iena), .istart(istart), .iabort(iabort),
    .iframe_len(iframe_len), .iwin_half(iwin_half), .isop_sync(isop_sync),
    .ocorr_sop(ocorr_sop), .ostate(ostate), .olock(olock),
    .oframe_sop(oframe_sop), .otime_err(otime_err)
  );

  always #5 iclk = ~iclk;

  // Model: tracks the absolute index of the next nominal frame start; window is nominal +/- W.
  int m_state, m_hits, m_miss, m_n, m_nom, m_L, m_W;
  logic e_lock, e_corr, e_fsop;
  logic signed [7:0] e_terr;

  task automatic model_reset();
    m_state = 0; m_hits = 0; m_miss = 0; m_n = 0; m_nom = 0;
    e_lock = 0; e_corr = 0; e_fsop = 0; e_terr = 0;
  endtask

  task automatic model_step(input logic e, input logic s, input logic a, input logic p);
    int off;
    e_corr = 0;
    e_fsop = 0;
    if (a) begin
      m_state = 0; e_lock = 0;
    end else if (s) begin
      m_state = 1; m_L = int'(iframe_len); m_W = int'(iwin_half);
      e_corr = 1; e_lock = 0;
    end else if (e) begin
      if (m_state == 1) begin
        if (p) begin
          m_state = 2; m_hits = 1; m_nom = m_n + m_L; e_terr = 0;
        end
      end else if (m_state >= 2) begin
        off = m_n - m_nom;
        if (p && off >= -m_W && off <= m_W) begin
          e_terr = 8'(off);
          m_nom = m_n + m_L;
          if (m_state == 2) begin
            m_hits++;
            if (m_hits == LOCK_N) begin
              m_state = 3; e_lock = 1; m_miss = 0; e_fsop = 1;
            end
          end else begin
            m_miss = 0; e_fsop = 1;
          end
        end else if (off == m_W) begin
          m_nom = m_nom + m_L;
          if (m_state == 2) begin
            m_state = 1; e_corr = 1;
          end else begin
            m_miss++;
            if (m_miss == LOSS_N) begin
              m_state = 1; e_lock = 0; e_corr = 1;
            end else begin
              e_fsop = 1;
            end
          end
        end
      end
    end
    if (e) m_n++;
  endtask

  task automatic chk(input string nm, input logic signed [31:0] act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", nm, act, exp);
    end
  endtask

  task automatic tick(input logic e, input logic s, input logic a, input logic p);
    iena = e; istart = s; iabort = a; isop_sync = p;
    model_step(e, s, a, p);
    @(posedge iclk);
    @(negedge iclk);
    iena = 0; istart = 0; iabort = 0; isop_sync = 0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick(1, 0, 0, 0);
  endtask

  task automatic do_reset();
    iena = 0; istart = 0; iabort = 0; isop_sync = 0;
    ireset = 1;
    model_reset();
    @(negedge iclk);
    ireset = 0;
  endtask

  task automatic lock_seq(input bit do_chk);
    tick(1, 1, 0, 0);
    if (do_chk) begin
      chk("start_corr", ocorr_sop, 1);
      chk("start_state", ostate, 1);
    end
    tick(1, 0, 0, 1);
    if (do_chk) begin
      chk("search_det_state", ostate, 2);
      chk("search_det_corr", ocorr_sop, 0);
    end
    idle(99);
    tick(1, 0, 0, 1);
    if (do_chk) chk("verify_hit2_state", ostate, 2);
    idle(99);
    tick(1, 0, 0, 1);
    if (do_chk) begin
      chk("lock_state", ostate, 3);
      chk("lock_olock", olock, 1);
      chk("lock_fsop", oframe_sop, 1);
      chk("lock_terr", otime_err, 0);
    end
  endtask

  typedef struct {
    logic e, s, a, p;
    int   st;
    logic lk, cs, fs;
  } vec_t;

  vec_t tbl[12];

  int fsop_cnt, corr_cnt, first_fsop, loss_k, left_verify;
  int src_cnt, src_tgt;
  logic r_e, r_s, r_a, r_p;

  initial begin
    tbl[0]  = '{0, 0, 0, 0, 0, 0, 0, 0};
    tbl[1]  = '{1, 0, 0, 1, 0, 0, 0, 0};
    tbl[2]  = '{1, 1, 0, 0, 1, 0, 1, 0};
    tbl[3]  = '{1, 0, 0, 0, 1, 0, 0, 0};
    tbl[4]  = '{0, 0, 0, 1, 1, 0, 0, 0};
    tbl[5]  = '{1, 0, 0, 1, 2, 0, 0, 0};
    tbl[6]  = '{0, 0, 0, 1, 2, 0, 0, 0};
    tbl[7]  = '{1, 0, 0, 0, 2, 0, 0, 0};
    tbl[8]  = '{1, 1, 1, 0, 0, 0, 0, 0};
    tbl[9]  = '{1, 1, 0, 0, 1, 0, 1, 0};
    tbl[10] = '{1, 1, 0, 1, 1, 0, 1, 0};
    tbl[11] = '{1, 0, 1, 1, 0, 0, 0, 0};

    model_reset();
    @(negedge iclk);
    chk("reset_outputs", {ostate, olock, ocorr_sop, oframe_sop, otime_err}, 0);
    ireset = 0;

    // Vector table, L=10 W=2
    iframe_len = 16'd10; iwin_half = 7'd2;
    for (int i = 0; i < 12; i++) begin
      tick(tbl[i].e, tbl[i].s, tbl[i].a, tbl[i].p);
      chk($sformatf("tbl_row%0d", i), {ostate, olock, ocorr_sop, oframe_sop},
          int'({tbl[i].st[1:0], tbl[i].lk, tbl[i].cs, tbl[i].fs}));
    end

    // Acquire, shifted detections and flywheel loss, L=100 W=4
    iframe_len = 16'd100; iwin_half = 7'd4;
    do_reset();
    lock_seq(1);
    idle(96);
    tick(1, 0, 0, 1);
    chk("early_terr", otime_err, -3);
    chk("early_fsop", oframe_sop, 1);
    idle(101);
    tick(1, 0, 0, 1);
    chk("late_terr", otime_err, 2);
    chk("late_fsop", oframe_sop, 1);
    tick(1, 0, 0, 0);
    chk("fsop_single", oframe_sop, 0);

    fsop_cnt = 0; corr_cnt = 0; first_fsop = -1; loss_k = -1;
    for (int k = 2; k <= 410; k++) begin
      tick(1, 0, 0, 0);
      if (oframe_sop) begin
        fsop_cnt++;
        if (first_fsop < 0) first_fsop = k;
      end
      if (ocorr_sop) corr_cnt++;
      if (loss_k < 0 && ostate == 2'd1) loss_k = k;
    end
    chk("loss_fsop_count", fsop_cnt, 3);
    chk("loss_first_fsop", first_fsop, 104);
    chk("loss_at_4th_miss", loss_k, 404);
    chk("loss_corr_count", corr_cnt, 1);
    chk("loss_olock", olock, 0);

    // Detection outside the window in VERIFY
    do_reset();
    tick(1, 1, 0, 0);
    tick(1, 0, 0, 1);
    idle(93);
    tick(1, 0, 0, 1);
    chk("outwin_ignored", ostate, 2);
    idle(9);
    chk("outwin_before_close", {ostate, ocorr_sop}, 4);
    tick(1, 0, 0, 0);
    chk("outwin_close_state", ostate, 1);
    chk("outwin_close_corr", ocorr_sop, 1);

    // start+abort together in TRACK, then asynchronous reset in TRACK
    do_reset();
    lock_seq(0);
    idle(20);
    tick(1, 1, 1, 0);
    chk("abort_wins", {ostate, olock, ocorr_sop}, 0);
    lock_seq(0);
    idle(10);
    #2 ireset = 1;
    #1 chk("async_reset_outputs", {ostate, olock, ocorr_sop, oframe_sop, otime_err}, 0);
    model_reset();
    @(negedge iclk);
    ireset = 0;
    tick(1, 0, 0, 1);
    chk("post_reset_idle", ostate, 0);

    // iena gating: detections on iena=0 cycles are ignored
    do_reset();
    tick(1, 1, 0, 0);
    tick(1, 0, 0, 1);
    left_verify = 0;
    for (int k = 1; k <= 200; k++) begin
      tick(1, 0, 0, (k == 100 || k == 200));
      if (k < 200) begin
        tick(0, 0, 0, 1);
        if (ostate != 2'd2) left_verify++;
      end
    end
    chk("gated_stay_verify", left_verify, 0);
    chk("gated_lock", {ostate, olock}, 7);

    // Random traffic against the model, L=20 W=3
    iframe_len = 16'd20; iwin_half = 7'd3;
    do_reset();
    tick(1, 1, 0, 0);
    src_cnt = 0; src_tgt = 20;
    for (int c = 0; c < 4000; c++) begin
      r_e = ($urandom_range(0, 7) != 0);
      r_p = 0;
      if (r_e) begin
        src_cnt++;
        if (src_cnt >= src_tgt) begin
          r_p = ($urandom_range(0, 7) != 0);
          src_cnt = 0;
          src_tgt = ($urandom_range(0, 3) == 0) ? 16 + $urandom_range(0, 8)
                                                : 19 + $urandom_range(0, 2);
        end
      end
      if ($urandom_range(0, 39) == 0) r_p = 1;
      r_s = ($urandom_range(0, 299) == 0);
      r_a = ($urandom_range(0, 499) == 0);
      tick(r_e, r_s, r_a, r_p);
      chk($sformatf("rand_cyc%0d", c), {ostate, olock, ocorr_sop, oframe_sop, otime_err},
          int'({m_state[1:0], e_lock, e_corr, e_fsop, e_terr}));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sync_track_ctrl.md
SYNC_TRACK_CTRL -- requirements
Module: sync_track_ctrl

Interface
REQ-001 SHALL have parameter pFRAME_W, default 16, width of frame-period counter and iframe_len.
REQ-002 SHALL have parameter pLOCK_N, default 3, consecutive in-window detections needed for lock (range 2..15).
REQ-003 SHALL have parameter pLOSS_N, default 4, consecutive misses in TRACK that drop lock (range 1..15).
REQ-004 SHALL have one clock; reset is asynchronous and active-high.
REQ-005 iclk  in  1  clock.
REQ-006 ireset  in  1  asynchronous, active-high reset.
REQ-007 iena  in  1  sample strobe; all counting and detection qualified by it.
REQ-008 istart  in  1  pulse: start or restart the search.
REQ-009 iabort  in  1  pulse: return to IDLE.
REQ-010 iframe_len  in  pFRAME_W  expected PSS spacing in samples (L).
REQ-011 iwin_half  in  7  tracking window half-width in samples (W).
REQ-012 isop_sync  in  1  detection pulse from PSS correlator.
REQ-013 ocorr_sop  out  1  one-cycle pulse that re-arms the PSS correlator (reference reload).
REQ-014 ostate  out  2  IDLE=0, SEARCH=1, VERIFY=2, TRACK=3.
REQ-015 olock  out  1  high while in TRACK.
REQ-016 oframe_sop  out  1  one-cycle frame-start strobe in TRACK.
REQ-017 otime_err  out  8 signed  timing offset of last accepted detection.

Function
REQ-018 SHALL latch iframe_len and iwin_half on every accepted istart; precondition 2*W+2 <= L, behaviour otherwise undefined.
REQ-019 Priority: iabort > istart > state logic; iabort in any state -> IDLE, counters cleared, no ocorr_sop.
REQ-020 istart in any state -> SEARCH, counters cleared, ocorr_sop pulsed the following cycle.
REQ-021 Every entry into SEARCH (istart, VERIFY failure, TRACK loss) SHALL produce exactly one ocorr_sop pulse, registered, one cycle after the causing event.
REQ-022 Period counter pcnt: increments on iena, wraps from L-1 to 0; free-runs in VERIFY and TRACK.
REQ-023 In-window: pcnt >= L-W or pcnt <= W; armed flag sets on iena with pcnt == L-W-1, clears on accept or close.
REQ-024 Accept = iena & isop_sync & armed & in-window; accepted sample is frame index 0, so pcnt becomes 1 next sample.
REQ-025 Close = iena & armed & pcnt == W & no accept that cycle -> one miss; accept on the same sample wins.
REQ-026 Detections outside window or when not armed SHALL be ignored in VERIFY and TRACK.
REQ-027 SEARCH: first iena & isop_sync -> VERIFY, pcnt=1, armed=0, hit_cnt=1.
REQ-028 VERIFY: accept -> hit_cnt+1; when count reaches pLOCK_N -> TRACK, olock=1, miss_cnt=0; any miss -> SEARCH.
REQ-029 TRACK: accept -> miss_cnt=0, pcnt realigned; miss -> miss_cnt+1, pcnt not realigned (flywheel); miss_cnt reaching pLOSS_N -> SEARCH, olock=0.
REQ-030 oframe_sop SHALL pulse one cycle after each accept that leaves the block in TRACK, and one cycle after each miss in TRACK that does not cause loss.
REQ-031 otime_err SHALL update on every accept in VERIFY/TRACK: pcnt if pcnt <= W else pcnt-L; held otherwise; SEARCH entry detection writes 0.
REQ-032 isop_sync without iena SHALL be ignored.

Reset
REQ-033 ireset high SHALL asynchronously force IDLE, pcnt=0, armed=0, hit_cnt=0, miss_cnt=0, and all outputs 0; release mid-operation resumes in IDLE only.

Verification
REQ-034 L=100, W=4, iena=1, istart then isop_sync every 100 samples -> ocorr_sop 1 cycle after istart, ostate 1->2->3, olock after 3rd detection, otime_err=0.
REQ-035 Locked, next detection 3 samples early then 2 late -> otime_err=-3 then +2, oframe_sop one cycle after each.
REQ-036 Locked, detections stop -> oframe_sop every 100 samples for 3 misses, 4th miss -> ostate=1, olock=0, one ocorr_sop.
REQ-037 VERIFY, detection at offset 6 (outside W=4) -> ignored, miss at close -> SEARCH, ocorr_sop pulsed.
REQ-038 istart and iabort same cycle while TRACK -> IDLE, no ocorr_sop; ireset mid-TRACK -> all outputs 0 immediately.
REQ-039 iena toggling 1/0, detection pulses on iena=0 cycles -> no state change, pcnt advances only on iena.
